// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART TX among word sources
// Latches the granted word and sends its low len+1 bytes MSB-first over tx_start/tx_done.
module uart_tx_arbiter #(
  parameter int NB_DATA  = 8,
  parameter int NB_WORD  = 32,
  parameter int N_REQ    = 3,
  parameter int NB_LEN   = 2,
  parameter int NB_STATE = 2
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*NB_WORD-1:0] i_req_data,
  input  logic [N_REQ*NB_LEN-1:0]  i_req_len,
  input  logic                     i_tx_done,
  output logic                     o_tx_start,
  output logic [NB_DATA-1:0]       o_tx_data,
  output logic [N_REQ-1:0]         o_grant,
  output logic [N_REQ-1:0]         o_word_done,
  output logic                     o_busy,
  output logic [NB_STATE-1:0]      o_state
);

  localparam int NB_PTR = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [NB_STATE-1:0] {
    IDLE    = NB_STATE'(0),
    SEND    = NB_STATE'(1),
    WAIT_TX = NB_STATE'(2),
    RELEASE = NB_STATE'(3)
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [NB_PTR-1:0]   ptr;
  logic [NB_PTR-1:0]   owner;
  logic [NB_PTR-1:0]   pick;
  logic [NB_PTR-1:0]   ptr_after;
  logic [NB_PTR:0]     cand;
  logic                pick_valid;
  logic [N_REQ-1:0]    pick_onehot;
  logic [N_REQ-1:0]    owner_onehot;
  logic [NB_WORD-1:0]  word;
  logic [NB_WORD-1:0]  word_shift;
  logic [NB_LEN-1:0]   len;
  logic [NB_LEN-1:0]   byte_idx;
  logic [NB_LEN-1:0]   byte_sel;
  logic                done_ok;
  logic                last_byte;

  // Walk downward so the requester closest to ptr is the last (winning) assignment.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    cand       = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (NB_PTR+1)'(i);
      if (cand >= (NB_PTR+1)'(N_REQ)) begin
        cand = cand - (NB_PTR+1)'(N_REQ);
      end
      if (i_req[cand[NB_PTR-1:0]]) begin
        pick_valid = 1'b1;
        pick       = cand[NB_PTR-1:0];
      end
    end
  end

  assign pick_onehot  = N_REQ'(1) << pick;
  assign owner_onehot = N_REQ'(1) << owner;
  assign ptr_after    = (owner == NB_PTR'(N_REQ - 1)) ? '0 : owner + 1'b1;
  assign byte_sel     = len - byte_idx;
  assign word_shift   = word >> (byte_sel * NB_DATA);
  // A done arriving while tx_start is still high belongs to an earlier byte.
  assign done_ok      = i_tx_done && !o_tx_start;
  assign last_byte    = (byte_idx == len);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_valid) state_next = SEND;
      SEND:    state_next = WAIT_TX;
      WAIT_TX: if (done_ok) state_next = last_byte ? RELEASE : SEND;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ptr         <= '0;
      owner       <= '0;
      word        <= '0;
      len         <= '0;
      byte_idx    <= '0;
      o_tx_start  <= 1'b0;
      o_tx_data   <= '0;
      o_grant     <= '0;
      o_word_done <= '0;
      o_busy      <= 1'b0;
    end else begin
      o_tx_start  <= 1'b0;
      o_word_done <= '0;
      o_busy      <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner    <= pick;
            word     <= i_req_data[pick*NB_WORD +: NB_WORD];
            len      <= i_req_len[pick*NB_LEN +: NB_LEN];
            byte_idx <= '0;
            o_grant  <= pick_onehot;
          end
        end
        SEND: begin
          o_tx_start <= 1'b1;
          o_tx_data  <= word_shift[NB_DATA-1:0];
        end
        WAIT_TX: begin
          if (done_ok) begin
            if (last_byte) begin
              o_grant     <= '0;
              o_word_done <= owner_onehot;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        RELEASE: begin
          ptr <= ptr_after;
        end
        default: ;
      endcase
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int DLY = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = '0;
  logic [95:0] req_data = '0;
  logic [5:0]  req_len = '0;
  logic        manual_done = 1'b0;
  logic        auto_done = 1'b0;
  logic        tx_done;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [2:0]  grant;
  logic [2:0]  word_done;
  logic        busy;
  logic [1:0]  state;

  assign tx_done = manual_done | auto_done;

  uart_tx_arbiter dut (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_req       (req),
    .i_req_data  (req_data),
    .i_req_len   (req_len),
    .i_tx_done   (tx_done),
    .o_tx_start  (tx_start),
    .o_tx_data   (tx_data),
    .o_grant     (grant),
    .o_word_done (word_done),
    .o_busy      (busy),
    .o_state     (state)
  );

  always #5 clock = ~clock;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] bytes_q[$];
  logic [2:0] grant_q[$];
  int         starts = 0;
  int         dones = 0;
  int         wd_cnt[3] = '{0, 0, 0};
  int         wd_total = 0;
  int         bytes_at_wd = 0;
  int         dones_at_wd = 0;
  int         grant_changes = 0;
  logic       multi_grant = 1'b0;
  logic [2:0] prev_grant = '0;
  int         pend = 0;

  // UART model and monitor, sampled mid-cycle
  always @(negedge clock) begin
    if (tx_start) begin
      bytes_q.push_back(tx_data);
      starts++;
    end
    if (word_done != 3'b000) begin
      for (int k = 0; k < 3; k++) if (word_done[k]) wd_cnt[k]++;
      wd_total++;
      bytes_at_wd = bytes_q.size();
      dones_at_wd = dones;
    end
    if ($countones(grant) > 1) multi_grant = 1'b1;
    if (grant != prev_grant) begin
      grant_changes++;
      if (prev_grant == 3'b000) grant_q.push_back(grant);
    end
    prev_grant = grant;
    if (reset) begin
      pend = 0;
      auto_done = 1'b0;
    end else begin
      if (auto_done) auto_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          auto_done = 1'b1;
          dones++;
        end
      end
      if (tx_start) pend = DLY;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_wd(input int k, input int target, input string tag);
    int c = 0;
    while (wd_cnt[k] < target && c < 300) begin
      step();
      c++;
    end
    check(tag, 32'(wd_cnt[k] >= target), 32'd1);
  endtask

  int b0, g0, s0, d0, w0, gc0;
  int wd0[3];

  initial begin
    step(2);
    reset = 1'b0;
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_word_done", 32'(word_done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_state", 32'(state), 0);

    // 1: four bytes MSB-first
    b0 = bytes_q.size(); s0 = starts; d0 = dones; gc0 = grant_changes; wd0 = wd_cnt;
    req_data[31:0] = 32'hDEADBEEF; req_len[1:0] = 2'd3; req = 3'b001;
    step();
    req = 3'b000;
    check("t1_state_send", 32'(state), 1);
    check("t1_grant", 32'(grant), 'h1);
    check("t1_busy", 32'(busy), 1);
    check("t1_no_start_yet", 32'(tx_start), 0);
    step();
    check("t1_state_wait", 32'(state), 2);
    check("t1_start", 32'(tx_start), 1);
    check("t1_first_byte", 32'(tx_data), 'hDE);
    wait_wd(0, wd0[0] + 1, "t1_wd_timeout");
    check("t1_nbytes", 32'(bytes_q.size() - b0), 4);
    check("t1_b0", 32'(bytes_q[b0]), 'hDE);
    check("t1_b1", 32'(bytes_q[b0+1]), 'hAD);
    check("t1_b2", 32'(bytes_q[b0+2]), 'hBE);
    check("t1_b3", 32'(bytes_q[b0+3]), 'hEF);
    check("t1_starts", 32'(starts - s0), 4);
    check("t1_wd_after_4th_done", 32'(dones_at_wd - d0), 4);
    check("t1_grant_steady", 32'(grant_changes - gc0), 2);
    step(2);
    check("t1_wd_once", 32'(wd_cnt[0] - wd0[0]), 1);
    check("t1_idle", 32'(state), 0);
    check("t1_not_busy", 32'(busy), 0);

    // 2: single byte from req2, pointer then favours req0
    b0 = bytes_q.size(); s0 = starts; wd0 = wd_cnt;
    req_data[95:64] = 32'h123456A5; req_len[5:4] = 2'd0; req = 3'b100;
    step();
    req = 3'b000;
    check("t2_grant", 32'(grant), 'h4);
    wait_wd(2, wd0[2] + 1, "t2_wd_timeout");
    check("t2_nbytes", 32'(bytes_q.size() - b0), 1);
    check("t2_byte", 32'(bytes_q[b0]), 'hA5);
    check("t2_wd2", 32'(wd_cnt[2] - wd0[2]), 1);
    req_data[31:0] = 32'h00000077; req_len[1:0] = 2'd0; req = 3'b101;
    step();
    req = 3'b000;
    check("t2_ptr_req0_wins", 32'(grant), 'h1);
    wait_wd(0, wd0[0] + 1, "t2_wd0_timeout");

    // 3: all requesters held high, round-robin order from ptr=0
    reset = 1'b1;
    step();
    reset = 1'b0;
    g0 = grant_q.size(); w0 = wd_total;
    req_data = {32'h000000C2, 32'h000000C1, 32'h000000C0};
    req_len = 6'b000000;
    req = 3'b111;
    for (int c = 0; c < 400 && wd_total < w0 + 5; c++) step();
    req = 3'b000;
    check("t3_words", 32'(wd_total - w0), 5);
    step(4);
    check("t3_ngrants", 32'(grant_q.size() - g0), 5);
    check("t3_g0", 32'(grant_q[g0]), 'h1);
    check("t3_g1", 32'(grant_q[g0+1]), 'h2);
    check("t3_g2", 32'(grant_q[g0+2]), 'h4);
    check("t3_g3", 32'(grant_q[g0+3]), 'h1);
    check("t3_g4", 32'(grant_q[g0+4]), 'h2);
    check("t3_one_hot", 32'(multi_grant), 0);

    // 4: spurious tx_done in IDLE, SEND and on the tx_start cycle
    b0 = bytes_q.size(); s0 = starts; wd0 = wd_cnt;
    manual_done = 1'b1;
    step();
    manual_done = 1'b0;
    check("t4_idle_stays", 32'(state), 0);
    req_data[63:32] = 32'h0000C3A7; req_len[3:2] = 2'd1; req = 3'b010;
    step();
    manual_done = 1'b1;
    check("t4_send", 32'(state), 1);
    step();
    req = 3'b000;
    check("t4_start_cycle", 32'(tx_start), 1);
    step();
    manual_done = 1'b0;
    check("t4_still_wait", 32'(state), 2);
    check("t4_no_early_wd", 32'(wd_cnt[1] - wd0[1]), 0);
    wait_wd(1, wd0[1] + 1, "t4_wd_timeout");
    check("t4_nbytes", 32'(bytes_q.size() - b0), 2);
    check("t4_b0", 32'(bytes_q[b0]), 'hC3);
    check("t4_b1", 32'(bytes_q[b0+1]), 'hA7);
    check("t4_wd_after_2", 32'(bytes_at_wd - b0), 2);

    // 5: reset mid-word, then restart and tie-break from ptr=0
    s0 = starts;
    req_data[63:32] = 32'h11223344; req_len[3:2] = 2'd3; req = 3'b010;
    step();
    req = 3'b000;
    for (int c = 0; c < 200 && starts < s0 + 3; c++) step();
    check("t5_in_wait", 32'(state), 2);
    reset = 1'b1;
    step();
    check("t5_rst_state", 32'(state), 0);
    check("t5_rst_start", 32'(tx_start), 0);
    check("t5_rst_data", 32'(tx_data), 0);
    check("t5_rst_grant", 32'(grant), 0);
    check("t5_rst_wd", 32'(word_done), 0);
    check("t5_rst_busy", 32'(busy), 0);
    reset = 1'b0;
    step();
    b0 = bytes_q.size(); wd0 = wd_cnt;
    req_data[31:0] = 32'h00000055; req_len[1:0] = 2'd0;
    req_data[63:32] = 32'hAABBCCDD; req_len[3:2] = 2'd3;
    req = 3'b011;
    step();
    req = 3'b010;
    check("t5_tie_req0", 32'(grant), 'h1);
    step();
    check("t5_b_req0", 32'(tx_data), 'h55);
    wait_wd(1, wd0[1] + 1, "t5_wd_timeout");
    req = 3'b000;
    check("t5_nbytes", 32'(bytes_q.size() - b0), 5);
    check("t5_restart_b0", 32'(bytes_q[b0+1]), 'hAA);
    check("t5_b1", 32'(bytes_q[b0+2]), 'hBB);
    check("t5_b3", 32'(bytes_q[b0+4]), 'hDD);

    // 6: request and data change after grant
    step(2);
    b0 = bytes_q.size(); wd0 = wd_cnt;
    req_data[31:0] = 32'h00A1B2C3; req_len[1:0] = 2'd2; req = 3'b001;
    step();
    req = 3'b000;
    req_data[31:0] = 32'hFFFFFFFF; req_len[1:0] = 2'd0;
    wait_wd(0, wd0[0] + 1, "t6_wd_timeout");
    check("t6_nbytes", 32'(bytes_q.size() - b0), 3);
    check("t6_b0", 32'(bytes_q[b0]), 'hA1);
    check("t6_b1", 32'(bytes_q[b0+1]), 'hB2);
    check("t6_b2", 32'(bytes_q[b0+2]), 'hC3);
    check("t6_wd0", 32'(wd_cnt[0] - wd0[0]), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
